// File: rtl/csel_subtractor16_seq.sv
// Sequential 16-bit subtractor/comparator: walks carry-select segments (1,1,2,3,4,5 bits)
// LSB to MSB, one per clock, selecting each segment's borrow-0/borrow-1 result on the running borrow.
module csel_subtractor16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NSEG = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_seg;
    logic             r_borrow;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_out_valid;

    logic [3:0]       w_lo;
    logic [4:0]       w_mask;
    logic [4:0]       w_xs;
    logic [4:0]       w_ys;
    logic [5:0]       w_d0;
    logic [5:0]       w_d1;
    logic [5:0]       w_dsel;
    logic             w_bsel;
    logic [WIDTH-1:0] w_diff_next;

    always_comb begin
        w_lo   = 4'd11;
        w_mask = 5'b11111;
        case (r_seg)
            3'd0:    begin w_lo = 4'd0; w_mask = 5'b00001; end
            3'd1:    begin w_lo = 4'd1; w_mask = 5'b00001; end
            3'd2:    begin w_lo = 4'd2; w_mask = 5'b00011; end
            3'd3:    begin w_lo = 4'd4; w_mask = 5'b00111; end
            3'd4:    begin w_lo = 4'd7; w_mask = 5'b01111; end
            default: begin w_lo = 4'd11; w_mask = 5'b11111; end
        endcase
    end

    // Segment values fit in 5 bits, so bit 5 of the 6-bit difference is the segment borrow.
    assign w_xs   = 5'(r_x >> w_lo) & w_mask;
    assign w_ys   = 5'(r_y >> w_lo) & w_mask;
    assign w_d0   = {1'b0, w_xs} - {1'b0, w_ys};
    assign w_d1   = w_d0 - 6'd1;
    assign w_dsel = r_borrow ? w_d1 : w_d0;
    assign w_bsel = w_dsel[5];

    assign w_diff_next = (r_diff & ~(WIDTH'(w_mask) << w_lo))
                       | (WIDTH'(w_dsel[4:0] & w_mask) << w_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_seg       <= 3'd0;
            r_borrow    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_borrow <= Bin;
                        r_seg    <= 3'd0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bsel;
                    if (r_seg == 3'(NSEG - 1)) begin
                        r_seg       <= 3'd0;
                        r_bout      <= w_bsel;
                        r_ovf       <= (r_x[WIDTH-1] != r_y[WIDTH-1]) &&
                                       (w_diff_next[WIDTH-1] != r_x[WIDTH-1]);
                        r_zero      <= (w_diff_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_seg <= r_seg + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign Ovf       = r_ovf;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_csel_subtractor16_seq.sv
// Directed and random checks of csel_subtractor16_seq against hand values and the 17-bit subtract equation.
module tb_csel_subtractor16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Diff;
    logic        Bout;
    logic        Ovf;
    logic        Zero;

    int n_assert = 0;
    int n_fail   = 0;

    csel_subtractor16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until out_valid is seen; 99 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
        int lat;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        x = a; y = b; Bin = bi; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd6);
        chk({tag, "_diff"}, 32'(Diff), 32'(ed));
        chk({tag, "_bout"}, 32'(Bout), 32'(eb));
        chk({tag, "_ovf"},  32'(Ovf),  32'(eo));
        chk({tag, "_zero"}, 32'(Zero), 32'(ez));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_retired"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int cyc;
        int t1;
        int t2;
        logic [16:0] ref17;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;
        logic        eo;

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_outputs",   32'({Diff, Bout, Ovf, Zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("t1",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("t2a",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("t2b",  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("t3a",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("t3b",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("t4",   16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Back-to-back with out_ready tied high: spacing between result pulses.
        x = 16'h0005; y = 16'h0004; Bin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && cyc < 40) begin
            tick();
            cyc++;
            if (out_valid) begin
                chk("b2b_diff", 32'(Diff), 32'h0);
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        in_valid = 1'b0;
        chk("b2b_interval", 32'(t2 - t1), 32'd8);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

        // Stall in DONE while new operands wait on in_valid.
        x = 16'h1234; y = 16'h0234; Bin = 1'b0; in_valid = 1'b1;
        tick();
        x = 16'h0100; y = 16'h0001;
        wait_valid(lat);
        chk("t5_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_diff",  32'({Diff, Bout, Ovf, Zero}), 32'({16'h1000, 3'b000}));
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("t5_new_latency", 32'(lat), 32'd6);
        chk("t5_new_diff", 32'({Diff, Bout, Ovf, Zero}), 32'({16'h00FF, 3'b000}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset with seg = 3 in flight.
        x = 16'hFFFF; y = 16'h0000; Bin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",   32'(out_valid), 32'd0);
        chk("t6_rst_ready",   32'(in_ready),  32'd0);
        chk("t6_rst_outputs", 32'({Diff, Bout, Ovf, Zero}), 32'd0);
        tick(); tick();
        chk("t6_rst_hold", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t6_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        run_op("t6_after", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            if (i < 16) begin
                ra = (i[0]) ? 16'hFFFF : 16'h0000;
                rb = (i[1]) ? 16'hFFFF : 16'h8000;
                rbi = i[2];
            end
            ref17 = {1'b0, ra} - {1'b0, rb} - 17'(rbi);
            eo = (ra[15] != rb[15]) && (ref17[15] != ra[15]);
            run_op("rand", ra, rb, rbi, ref17[15:0], ref17[16], eo, ref17[15:0] == 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
